// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the dot-product multiply sequencer.
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      ARM,
      WAIT,
      OUT
   } state_t;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_MAX_LEN = 16;

   // Enough headroom for MAX_LEN full-scale products.
   function automatic int acc_width(input int width, input int max_len);
      return width + $clog2(max_len);
   endfunction

   function automatic int cnt_width(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

endpackage

// File: rtl/mult_dot_seq.sv
// Issues one multiply per accepted operand pair and accumulates the products
// into a dot-product sum that is presented once per vector.
//
// state | meaning
// IDLE  | ready for the next operand pair
// ISSUE | start pulse to the multiplier
// ARM   | skip one cycle so a stale done from the previous product is ignored
// WAIT  | waiting for mult_done, then accumulate
// OUT   | sum presented until the consumer takes it
module mult_dot_seq
   import mult_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int ACC_W   = acc_width(WIDTH, MAX_LEN)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH/2-1:0]            in_a,
   input  logic [WIDTH/2-1:0]            in_b,
   input  logic                          in_last,
   output logic                          mult_start,
   output logic [WIDTH/2-1:0]            mult_a,
   output logic [WIDTH/2-1:0]            mult_b,
   input  logic [WIDTH-1:0]              mult_result,
   input  logic                          mult_done,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W-1:0]              out_sum,
   output logic [cnt_width(MAX_LEN)-1:0] out_count,
   output logic                          out_trunc
);

   localparam int OP_W  = WIDTH / 2;
   localparam int CNT_W = cnt_width(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               mult_start_q, mult_start_d;
   logic [OP_W-1:0]    mult_a_q, mult_a_d;
   logic [OP_W-1:0]    mult_b_q, mult_b_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_sum_q, out_sum_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               out_trunc_q, out_trunc_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic [ACC_W-1:0]   acc_sum;
   logic               vec_end;

   assign acc_sum = acc_q + ACC_W'(mult_result);
   assign vec_end = last_q || (cnt_q == CNT_MAX);

   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      mult_start_d = mult_start_q;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_count_d  = out_count_q;
      out_trunc_d  = out_trunc_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mult_a_d     = in_a;
               mult_b_d     = in_b;
               last_d       = in_last;
               cnt_d        = cnt_q + CNT_W'(1);
               in_ready_d   = 1'b0;
               mult_start_d = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            mult_start_d = 1'b0;
            state_d      = ARM;
         end
         ARM: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (mult_done) begin
               acc_d = acc_sum;
               if (vec_end) begin
                  out_valid_d = 1'b1;
                  out_sum_d   = acc_sum;
                  out_count_d = cnt_q;
                  out_trunc_d = !last_q && (cnt_q == CNT_MAX);
                  state_d     = OUT;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               acc_d       = '0;
               cnt_d       = '0;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            in_ready_d = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         mult_start_q <= 1'b0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_count_q  <= '0;
         out_trunc_q  <= 1'b0;
         acc_q        <= '0;
         cnt_q        <= '0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         mult_start_q <= mult_start_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_count_q  <= out_count_d;
         out_trunc_q  <= out_trunc_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mult_start = mult_start_q;
   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign out_valid  = out_valid_q;
   assign out_sum    = out_sum_q;
   assign out_count  = out_count_q;
   assign out_trunc  = out_trunc_q;

endmodule

// File: tb/tb_mult_dot_seq.sv
// Bench for mult_dot_seq: behavioural multiplier, vector-level sum model, directed vectors.
module tb_mult_dot_seq;

   localparam int WIDTH   = 32;
   localparam int MAX_LEN = 16;
   localparam int ACC_W   = 36;
   localparam int OP_W    = 16;
   localparam int CNT_W   = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [OP_W-1:0]    in_a = '0;
   logic [OP_W-1:0]    in_b = '0;
   logic               in_last = 1'b0;
   logic               mult_start;
   logic [OP_W-1:0]    mult_a;
   logic [OP_W-1:0]    mult_b;
   logic [WIDTH-1:0]   mult_result = '0;
   logic               mult_done = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [ACC_W-1:0]   out_sum;
   logic [CNT_W-1:0]   out_count;
   logic               out_trunc;

   mult_dot_seq #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_result(mult_result), .mult_done(mult_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_trunc(out_trunc)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Multiplier model: done is a level that drops on start (or one cycle later
   // when stale_delay is set) and rises mult_lat cycles after start.
   int              mult_lat = 3;
   bit              stale_delay = 1'b0;
   bit              m_busy = 1'b0;
   bit              m_pend_clr = 1'b0;
   int              m_lcnt = 0;
   logic [OP_W-1:0] m_pa = '0;
   logic [OP_W-1:0] m_pb = '0;

   always @(posedge clk) begin
      logic st;
      st = mult_start;
      #1;
      if (st) begin
         m_pa   = mult_a;
         m_pb   = mult_b;
         m_busy = 1'b1;
         m_lcnt = mult_lat;
         if (stale_delay) m_pend_clr = 1'b1;
         else mult_done = 1'b0;
      end else begin
         if (m_pend_clr) begin
            mult_done  = 1'b0;
            m_pend_clr = 1'b0;
         end
         if (m_busy) begin
            if (m_lcnt <= 1) begin
               mult_done   = 1'b1;
               mult_result = WIDTH'(m_pa) * WIDTH'(m_pb);
               m_busy      = 1'b0;
            end else begin
               m_lcnt--;
            end
         end
      end
   end

   // Vector model: sum of products of the accepted pairs, closed by last or MAX_LEN.
   typedef struct {
      logic [ACC_W-1:0] sum;
      int               count;
      bit               trunc;
   } exp_t;

   exp_t             exp_q[$];
   logic [ACC_W-1:0] m_acc = '0;
   int               m_n = 0;
   int               accepted = 0;
   int               starts = 0;

   always @(negedge clk) begin
      if (reset) begin
         m_acc = '0;
         m_n   = 0;
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            m_acc += ACC_W'(in_a) * ACC_W'(in_b);
            m_n++;
            accepted++;
            if (in_last || m_n == MAX_LEN) begin
               exp_q.push_back('{m_acc, m_n, (!in_last && m_n == MAX_LEN)});
               m_acc = '0;
               m_n   = 0;
            end
         end
         if (mult_start) starts++;
      end
   end

   // Compare process: outputs checked on every cycle they are valid.
   bit               hold_v = 1'b0;
   logic [ACC_W-1:0] h_sum;
   logic [CNT_W-1:0] h_count;
   logic             h_trunc;
   logic [ACC_W-1:0] last_sum = '0;
   logic [CNT_W-1:0] last_count = '0;
   logic             last_trunc = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         hold_v = 1'b0;
      end else if (out_valid) begin
         check("in_ready_low_in_out", in_ready, 0);
         if (hold_v) begin
            check("out_sum_stable", out_sum, h_sum);
            check("out_count_stable", out_count, h_count);
            check("out_trunc_stable", out_trunc, h_trunc);
         end
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_sum", out_sum, e.sum);
               check("out_count", out_count, e.count);
               check("out_trunc", out_trunc, e.trunc);
            end
            last_sum   = out_sum;
            last_count = out_count;
            last_trunc = out_trunc;
            hold_v     = 1'b0;
         end else begin
            hold_v  = 1'b1;
            h_sum   = out_sum;
            h_count = out_count;
            h_trunc = out_trunc;
         end
      end else begin
         if (hold_v) check("out_valid_dropped", 0, 1);
         hold_v = 1'b0;
      end
   end

   task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic last);
      int k = 0;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) check("send_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_outputs(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check(name, (exp_q.size() == 0), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_mult_start"}, mult_start, 0);
      check({tag, "_mult_a"}, mult_a, 0);
      check({tag, "_mult_b"}, mult_b, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_sum"}, out_sum, 0);
      check({tag, "_out_count"}, out_count, 0);
      check({tag, "_out_trunc"}, out_trunc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single pair
      s0 = starts;
      send(16'd3, 16'd5, 1'b1);
      wait_outputs("t1_done");
      check("t1_sum_lit", last_sum, 15);
      check("t1_count_lit", last_count, 1);
      check("t1_trunc_lit", last_trunc, 0);
      check("t1_one_start", starts - s0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_out_ready_no_effect", out_valid, 0);
      end
      @(posedge clk);
      #1;

      // three-pair vector
      send(16'd1, 16'd2, 1'b0);
      send(16'd3, 16'd4, 1'b0);
      send(16'd5, 16'd6, 1'b1);
      wait_outputs("t2_done");
      check("t2_sum_lit", last_sum, 44);
      check("t2_count_lit", last_count, 3);

      // full-scale truncated vector
      for (int i = 0; i < MAX_LEN; i++) send(16'hFFFF, 16'hFFFF, 1'b0);
      wait_outputs("t3_done");
      check("t3_sum_lit", last_sum, 36'hF_FFE0_0010);
      check("t3_count_lit", last_count, 16);
      check("t3_trunc_lit", last_trunc, 1);

      // last exactly at MAX_LEN is not truncation
      for (int i = 0; i < MAX_LEN; i++) send(16'd1, 16'(i), (i == MAX_LEN - 1));
      wait_outputs("t3b_done");
      check("t3b_sum_lit", last_sum, 120);
      check("t3b_trunc_lit", last_trunc, 0);

      // back-pressure on the output
      out_ready = 1'b0;
      send(16'd7, 16'd3, 1'b1);
      begin
         int k = 0;
         while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
         end
      end
      repeat (10) @(negedge clk);
      check("t4_valid_held", out_valid, 1);
      check("t4_in_ready_low", in_ready, 0);
      check("t4_sum_held", out_sum, 21);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_outputs("t4_done");
      send(16'd1, 16'd1, 1'b1);
      wait_outputs("t4b_done");
      check("t4b_sum_lit", last_sum, 1);

      // stale done still high when the next start fires
      stale_delay = 1'b1;
      send(16'd7, 16'd9, 1'b1);
      wait_outputs("t5_done");
      check("t5_sum_lit", last_sum, 63);
      stale_delay = 1'b0;

      // reset in WAIT, late done arrives while idle
      mult_lat = 6;
      send(16'd10, 16'd10, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 check_reset_outputs("rst_wait");
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("t6_late_done_ignored_valid", out_valid, 0);
      check("t6_late_done_ignored_ready", in_ready, 1);
      mult_lat = 3;
      send(16'd2, 16'd2, 1'b1);
      wait_outputs("t6_done");
      check("t6_sum_lit", last_sum, 4);
      check("t6_count_lit", last_count, 1);

      check("accepted_vs_starts", starts, accepted);
      check("no_pending_outputs", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_dot_seq.md
Name: mult_dot_seq

Overview:
- Upstream sequencer for the sequential shift-add multiplier. It accepts a stream of 16-bit operand pairs over a valid/ready handshake and issues one multiply at a time.
- It collects each product and accumulates the products into a dot-product sum.
- At the end of each vector it presents the sum on a valid/ready output.

Parameters:
- WIDTH, 32, product width; operands are WIDTH/2 bits, matching the multiplier.
- MAX_LEN, 16, maximum number of pairs per vector; power of two, at least 2.
- ACC_W, WIDTH+$clog2(MAX_LEN), accumulator width; guarantees no sum overflow.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  WIDTH/2  multiplicand.
- in_b  in  WIDTH/2  multiplier.
- in_last  in  1  this pair ends the vector.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_a  out  WIDTH/2  registered operand, stable from start until done.
- mult_b  out  WIDTH/2  registered operand, stable from start until done.
- mult_result  in  WIDTH  product from the multiplier.
- mult_done  in  1  multiplier done; level that stays high until the next start.
- out_valid  out  1  sum valid.
- out_ready  in  1  consumer accepts the sum.
- out_sum  out  ACC_W  dot-product sum.
- out_count  out  $clog2(MAX_LEN)+1  pairs in the vector.
- out_trunc  out  1  vector was force-terminated at MAX_LEN without in_last.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; in_ready=1.
  - mult_start=0, mult_a=0, mult_b=0.
  - out_valid=0, out_sum=0, out_count=0, out_trunc=0.
  - Internal acc=0, cnt=0, last_r=0.
  - Reset while in any state aborts the vector; partial sums are discarded. If the multiplier is busy, a late mult_done is ignored because state is IDLE.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_a/in_b into mult_a/mult_b, latch in_last into last_r, cnt<=cnt+1, then go to ISSUE. in_ready=0 in every other state.
  - ISSUE: mult_start=1 for exactly this cycle, then go to ARM.
  - ARM: one cycle in which mult_done is ignored, since a stale done from the previous product is still high until the multiplier clears it on start. Then go to WAIT.
  - WAIT: on mult_done=1, acc<=acc+zero-extended mult_result.
    - If last_r=1 or cnt==MAX_LEN: go to OUT, load out_sum from the new accumulated value, out_count<=cnt, out_trunc<=(!last_r && cnt==MAX_LEN).
    - Otherwise go to IDLE.
  - OUT: out_valid=1, with out_sum, out_count and out_trunc held stable until out_ready. On out_valid&&out_ready: acc<=0, cnt<=0, out_valid<=0, go to IDLE. Data outputs hold their values after the handshake.
- Handshake: input transfer occurs on in_valid&&in_ready; output transfer on out_valid&&out_ready. in_ready does not depend combinationally on in_valid.
- Latency: element accepted at edge 0; mult_start high in cycle 1; product added on the first edge where WAIT sees mult_done; out_valid rises on the following cycle.
- Arithmetic: unsigned only. The accumulator cannot overflow for MAX_LEN full-scale products.
- Boundaries:
  - A pair arriving with in_last at cnt==MAX_LEN reports out_trunc=0.
  - A vector of one pair is legal.
  - out_ready held high while idle has no effect.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, ISSUE, ARM, WAIT, OUT}.
  - Default WIDTH and MAX_LEN constants.
  - Function computing ACC_W and count width.
- Single module, no sub-module. The accumulator and FSM are small enough to stay in one module.

Test Plan:
- Single pair a=3, b=5, in_last=1 -> out_sum=15, out_count=1, out_trunc=0. Exactly one mult_start pulse is observed.
- Vector (1,2),(3,4),(5,6) with last on the third pair -> out_sum=44, out_count=3. Each pair waits for its own done; no pair is accepted while in_ready=0.
- 16 pairs of 0xFFFF×0xFFFF without in_last -> out_sum=0xF_FFE0_0010, out_count=16, out_trunc=1.
- out_ready held low for 10 cycles in OUT -> out_valid and out_sum are stable and in_ready=0. Asserting out_ready completes the transfer, and the next vector starts with acc=0.
- Stale done: mult_done already high when ISSUE fires and the model delays clearing it by one cycle -> the product is not accumulated until the genuine done. The sum is correct (7×9=63).
- Reset asserted for one cycle in WAIT mid-vector, then vector (2,2) with last -> all outputs at reset values during reset. The late done is ignored, and the new vector returns out_sum=4, out_count=1.
